simmem_row_scheduler: RTL and testbench

//  Single-bank DRAM timing scheduler for the simulated memory controller. It accepts write-address
//  and read-address bursts, each tagged with its response-bank internal ID (iid), and arbitrates

---
 rtl/simmem_pkg.sv | 65 ++++++
 rtl/simmem_row_cost_calc.sv | 51 +++++
 rtl/simmem_row_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_simmem_row_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simmem_pkg.sv
// ---------------------------------------------------------------------------
// simmem_pkg
// Shared types, constants and helpers for the simulated memory controller.
//   - address/iid types for the write-address and read-address channels
//   - response bank selector (WRSP_BANK / RDATA_BANK)
//   - DRAM timing costs and row-buffer geometry
//   - row scheduler state encoding and helper functions
// ---------------------------------------------------------------------------
package simmem_pkg;

  // Address geometry: a row buffer holds 2**RowBufLenW bytes.
  localparam int unsigned AxAddrWidth = 20;
  localparam int unsigned RowBufLenW  = 10;
  localparam int unsigned RowIdWidth  = AxAddrWidth - RowBufLenW;
  localparam int unsigned AxLenWidth  = 8;

  // Only the low MaxBurstLenField bits of burst_len are meaningful.
  localparam int unsigned MaxBurstLenField = 2;
  localparam int unsigned MaxBurstEffLen   = 2 ** (2 ** MaxBurstLenField - 1);

  localparam int unsigned WriteIidWidth = 4;
  localparam int unsigned ReadIidWidth  = 5;

  // DRAM timing in cycles.
  localparam int unsigned RowHitCost     = 10;
  localparam int unsigned PrechargeCost  = 50;
  localparam int unsigned ActivationCost = 45;

  typedef logic [WriteIidWidth-1:0] write_iid_t;
  typedef logic [ReadIidWidth-1:0]  read_iid_t;
  typedef logic [RowIdWidth-1:0]    row_id_t;

  typedef struct packed {
    logic [AxLenWidth-1:0]  burst_len;
    logic [AxAddrWidth-1:0] addr;
  } waddr_t;

  typedef struct packed {
    logic [AxLenWidth-1:0]  burst_len;
    logic [AxAddrWidth-1:0] addr;
  } raddr_t;

  typedef enum logic {
    WRSP_BANK  = 1'b0,
    RDATA_BANK = 1'b1
  } rsp_bank_type_e;

  typedef enum logic [1:0] {
    SCHED_IDLE,
    SCHED_BUSY,
    SCHED_RELEASE
  } sched_state_e;

  // Row id is the address with the in-row byte offset stripped.
  function automatic row_id_t get_row_id(input logic [AxAddrWidth-1:0] addr);
    return row_id_t'(addr >> RowBufLenW);
  endfunction

  // Number of column accesses charged for a burst length field.
  function automatic int unsigned get_effective_burst_len(
      input logic [MaxBurstLenField-1:0] burst_len);
    return 32'd1 << burst_len;
  endfunction

endpackage

// File: rtl/simmem_row_cost_calc.sv
// ---------------------------------------------------------------------------
// simmem_row_cost_calc
// Purely combinational service-time calculator for one burst.
//   cost = rowcost + effective_burst_len - 1
//   rowcost: HitCost on an open-row hit, ActCost+HitCost with no open row,
//            PreCost+ActCost+HitCost on a row conflict.
// Ports:
//   row_open_i   in   a row is currently held in the row buffer
//   open_row_i   in   id of the open row
//   addr_i       in   burst start address
//   burst_len_i  in   burst length field (only the low bits are used)
//   cost_o       out  service cycles for this burst
// ---------------------------------------------------------------------------
module simmem_row_cost_calc
  import simmem_pkg::*;
#(
  parameter int unsigned HitCost = RowHitCost,
  parameter int unsigned PreCost = PrechargeCost,
  parameter int unsigned ActCost = ActivationCost,
  parameter int unsigned CostW   = 7
) (
  input  logic                   row_open_i,
  input  logic [RowIdWidth-1:0]  open_row_i,
  input  logic [AxAddrWidth-1:0] addr_i,
  input  logic [AxLenWidth-1:0]  burst_len_i,
  output logic [CostW-1:0]       cost_o
);

  logic [MaxBurstLenField-1:0] len_field;
  logic [CostW-1:0]            eff_len;
  logic [CostW-1:0]            rowcost;

  // Upper length bits are illegal upstream and deliberately ignored.
  logic unused_len_hi;
  assign unused_len_hi = ^burst_len_i[AxLenWidth-1:MaxBurstLenField];

  assign len_field = burst_len_i[MaxBurstLenField-1:0];
  assign eff_len   = CostW'(get_effective_burst_len(len_field));

  always_comb begin
    rowcost = CostW'(PreCost + ActCost + HitCost);
    if (!row_open_i) begin
      rowcost = CostW'(ActCost + HitCost);
    end else if (get_row_id(addr_i) == open_row_i) begin
      rowcost = CostW'(HitCost);
    end
  end

  assign cost_o = rowcost + eff_len - CostW'(1);

endmodule

// File: rtl/simmem_row_scheduler.sv
// ---------------------------------------------------------------------------
// simmem_row_scheduler
// Single-bank DRAM timing scheduler. Round-robin arbitrates between write and
// read address bursts, charges a row-buffer dependent delay per burst, then
// releases the burst's iid to the write-response or read-data bank.
// Build option: define SIMMEM_CLOSE_PAGE_EN for a close-page policy (row
// never held open, every burst pays activation); default is open-page.
// Ports:
//   clk_i, rst_ni                  clock, async active-low reset
//   waddr_valid_i/ready_o/i/iid_i  write burst request channel
//   raddr_valid_i/ready_o/i/iid_i  read burst request channel
//   done_valid_o/ready_i           release handshake toward response banks
//   done_type_o                    which bank the release targets
//   done_wiid_o / done_riid_o      released iid (the other one reads 0)
//   row_open_o / open_row_o        row buffer status
//   busy_o                         a burst is in service or awaiting release
// ---------------------------------------------------------------------------
module simmem_row_scheduler
  import simmem_pkg::*;
#(
  parameter int unsigned HitCost = RowHitCost,
  parameter int unsigned PreCost = PrechargeCost,
  parameter int unsigned ActCost = ActivationCost
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     waddr_valid_i,
  output logic                     waddr_ready_o,
  input  waddr_t                   waddr_i,
  input  logic [WriteIidWidth-1:0] waddr_iid_i,
  input  logic                     raddr_valid_i,
  output logic                     raddr_ready_o,
  input  raddr_t                   raddr_i,
  input  logic [ReadIidWidth-1:0]  raddr_iid_i,
  output logic                     done_valid_o,
  input  logic                     done_ready_i,
  output rsp_bank_type_e           done_type_o,
  output logic [WriteIidWidth-1:0] done_wiid_o,
  output logic [ReadIidWidth-1:0]  done_riid_o,
  output logic                     row_open_o,
  output logic [RowIdWidth-1:0]    open_row_o,
  output logic                     busy_o
);

  localparam int unsigned CostW = $clog2(PreCost + ActCost + HitCost + MaxBurstEffLen);

  sched_state_e     state_q, state_d;
  logic [CostW-1:0] cnt_q, cnt_d;
  rsp_bank_type_e   last_grant_q, last_grant_d;
  rsp_bank_type_e   type_q, type_d;
  write_iid_t       wiid_q, wiid_d;
  read_iid_t        riid_q, riid_d;

  logic                   grant_w, grant_r;
  logic [AxAddrWidth-1:0] sel_addr;
  logic [AxLenWidth-1:0]  sel_len;
  logic                   calc_row_open;
  row_id_t                calc_open_row;
  logic [CostW-1:0]       cost;

  // Round-robin: on contention grant the type not granted last time.
  // A grant is only issued to a valid requester, so grant == handshake.
  always_comb begin
    grant_w = 1'b0;
    grant_r = 1'b0;
    if (state_q == SCHED_IDLE) begin
      if (waddr_valid_i && raddr_valid_i) begin
        grant_w = (last_grant_q == RDATA_BANK);
        grant_r = (last_grant_q == WRSP_BANK);
      end else begin
        grant_w = waddr_valid_i;
        grant_r = raddr_valid_i;
      end
    end
  end

  assign waddr_ready_o = grant_w;
  assign raddr_ready_o = grant_r;
  assign sel_addr      = grant_r ? raddr_i.addr : waddr_i.addr;
  assign sel_len       = grant_r ? raddr_i.burst_len : waddr_i.burst_len;

`ifdef SIMMEM_CLOSE_PAGE_EN
  // Precharge is hidden after every burst, so each one starts from a closed row.
  assign calc_row_open = 1'b0;
  assign calc_open_row = '0;
  assign row_open_o    = 1'b0;
  assign open_row_o    = '0;
`else
  logic    row_open_q;
  row_id_t open_row_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_open_q <= 1'b0;
      open_row_q <= '0;
    end else if (grant_w || grant_r) begin
      row_open_q <= 1'b1;
      open_row_q <= get_row_id(sel_addr);
    end
  end

  assign calc_row_open = row_open_q;
  assign calc_open_row = open_row_q;
  assign row_open_o    = row_open_q;
  assign open_row_o    = open_row_q;
`endif

  simmem_row_cost_calc #(
    .HitCost (HitCost),
    .PreCost (PreCost),
    .ActCost (ActCost),
    .CostW   (CostW)
  ) u_cost_calc (
    .row_open_i  (calc_row_open),
    .open_row_i  (calc_open_row),
    .addr_i      (sel_addr),
    .burst_len_i (sel_len),
    .cost_o      (cost)
  );

  // Counter is loaded with cost-1 so done_valid rises exactly cost cycles
  // after the accepting edge.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    type_d       = type_q;
    wiid_d       = wiid_q;
    riid_d       = riid_q;
    case (state_q)
      SCHED_IDLE: begin
        if (grant_w) begin
          state_d      = SCHED_BUSY;
          last_grant_d = WRSP_BANK;
          type_d       = WRSP_BANK;
          wiid_d       = waddr_iid_i;
          cnt_d        = cost - CostW'(1);
        end else if (grant_r) begin
          state_d      = SCHED_BUSY;
          last_grant_d = RDATA_BANK;
          type_d       = RDATA_BANK;
          riid_d       = raddr_iid_i;
          cnt_d        = cost - CostW'(1);
        end
      end
      SCHED_BUSY: begin
        if (cnt_q == '0) begin
          state_d = SCHED_RELEASE;
        end else begin
          cnt_d = cnt_q - CostW'(1);
        end
      end
      SCHED_RELEASE: begin
        if (done_ready_i) begin
          state_d = SCHED_IDLE;
        end
      end
      default: state_d = SCHED_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= SCHED_IDLE;
      cnt_q        <= '0;
      last_grant_q <= RDATA_BANK;
      type_q       <= WRSP_BANK;
      wiid_q       <= '0;
      riid_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      type_q       <= type_d;
      wiid_q       <= wiid_d;
      riid_q       <= riid_d;
    end
  end

  // Release fields are forced to 0 outside RELEASE so idle/reset outputs are clean.
  assign done_valid_o = (state_q == SCHED_RELEASE);
  assign done_type_o  = done_valid_o ? type_q : WRSP_BANK;
  assign done_wiid_o  = (done_valid_o && type_q == WRSP_BANK) ? wiid_q : '0;
  assign done_riid_o  = (done_valid_o && type_q == RDATA_BANK) ? riid_q : '0;
  assign busy_o       = (state_q != SCHED_IDLE);

endmodule

// File: tb/tb_simmem_row_scheduler.sv
module tb_simmem_row_scheduler;
  import simmem_pkg::*;

`ifdef SIMMEM_CLOSE_PAGE_EN
  localparam bit ClosePage = 1'b1;
`else
  localparam bit ClosePage = 1'b0;
`endif

  logic           clk_i = 1'b0;
  logic           rst_ni = 1'b0;
  logic           waddr_valid_i = 1'b0;
  logic           waddr_ready_o;
  waddr_t         waddr_i = '0;
  write_iid_t     waddr_iid_i = '0;
  logic           raddr_valid_i = 1'b0;
  logic           raddr_ready_o;
  raddr_t         raddr_i = '0;
  read_iid_t      raddr_iid_i = '0;
  logic           done_valid_o;
  logic           done_ready_i = 1'b0;
  rsp_bank_type_e done_type_o;
  write_iid_t     done_wiid_o;
  read_iid_t      done_riid_o;
  logic           row_open_o;
  row_id_t        open_row_o;
  logic           busy_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  simmem_row_scheduler dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .waddr_valid_i (waddr_valid_i),
    .waddr_ready_o (waddr_ready_o),
    .waddr_i       (waddr_i),
    .waddr_iid_i   (waddr_iid_i),
    .raddr_valid_i (raddr_valid_i),
    .raddr_ready_o (raddr_ready_o),
    .raddr_i       (raddr_i),
    .raddr_iid_i   (raddr_iid_i),
    .done_valid_o  (done_valid_o),
    .done_ready_i  (done_ready_i),
    .done_type_o   (done_type_o),
    .done_wiid_o   (done_wiid_o),
    .done_riid_o   (done_riid_o),
    .row_open_o    (row_open_o),
    .open_row_o    (open_row_o),
    .busy_o        (busy_o)
  );

  // Present one burst, wait for acceptance, count cycles until done_valid.
  // Called just after a rising edge; returns on a falling edge with the
  // release pending (lat = -1 if it never arrived).
  task automatic issue(input bit is_w, input logic [19:0] addr, input logic [7:0] len,
                       input logic [4:0] iid, output int lat);
    int guard;
    int k;
    lat = -1;
    if (is_w) begin
      waddr_i.addr = addr; waddr_i.burst_len = len; waddr_iid_i = iid[3:0]; waddr_valid_i = 1'b1;
    end else begin
      raddr_i.addr = addr; raddr_i.burst_len = len; raddr_iid_i = iid; raddr_valid_i = 1'b1;
    end
    guard = 0;
    @(negedge clk_i);
    while (!(is_w ? waddr_ready_o : raddr_ready_o) && guard < 50) begin
      @(negedge clk_i);
      guard++;
    end
    total++;
    if (guard >= 50) begin
      bad++;
      $display("FAIL accept_timeout: ready never seen for addr %h", addr);
      waddr_valid_i = 1'b0; raddr_valid_i = 1'b0;
      return;
    end
    @(posedge clk_i); #1;
    waddr_valid_i = 1'b0; raddr_valid_i = 1'b0;
    k = 0;
    @(negedge clk_i);
    while (!done_valid_o && k < 300) begin
      @(posedge clk_i);
      k++;
      @(negedge clk_i);
    end
    if (done_valid_o) lat = k;
  endtask

  // Hand the pending release to the response bank; returns just after a rising edge.
  task automatic release_done();
    done_ready_i = 1'b1;
    @(posedge clk_i); #1;
    done_ready_i = 1'b0;
  endtask

  task automatic do_reset();
    waddr_valid_i = 1'b0; raddr_valid_i = 1'b0; done_ready_i = 1'b0;
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset();
    waddr_valid_i = 1'b0; raddr_valid_i = 1'b0; done_ready_i = 1'b0;
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    total++;
    if ({done_valid_o, waddr_ready_o, raddr_ready_o, busy_o, row_open_o} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got v=%b wr=%b rr=%b busy=%b ro=%b, want all 0",
               done_valid_o, waddr_ready_o, raddr_ready_o, busy_o, row_open_o);
    end
    total++;
    if (open_row_o !== '0 || done_wiid_o !== '0 || done_riid_o !== '0 || done_type_o !== WRSP_BANK) begin
      bad++;
      $display("FAIL reset_data: got row=%h wiid=%h riid=%h type=%b, want 0",
               open_row_o, done_wiid_o, done_riid_o, done_type_o);
    end
    @(posedge clk_i); #1 rst_ni = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_open_page();
    int lat;
    do_reset();
    issue(1'b1, 20'h00400, 8'd0, 5'd5, lat);
    total++;
    if (lat !== 55) begin bad++; $display("FAIL write_first_lat: got %0d want 55", lat); end
    total++;
    if (done_type_o !== WRSP_BANK || done_wiid_o !== 4'd5 || done_riid_o !== 5'd0) begin
      bad++;
      $display("FAIL write_first_rsp: got type=%b wiid=%0d riid=%0d want 0/5/0",
               done_type_o, done_wiid_o, done_riid_o);
    end
    total++;
    if (row_open_o !== 1'b1 || open_row_o !== 10'h001) begin
      bad++;
      $display("FAIL write_first_row: got open=%b row=%h want 1/001", row_open_o, open_row_o);
    end
    release_done();
    issue(1'b0, 20'h007FC, 8'd2, 5'd3, lat);
    total++;
    if (lat !== 13) begin bad++; $display("FAIL read_hit_lat: got %0d want 13", lat); end
    total++;
    if (done_type_o !== RDATA_BANK || done_riid_o !== 5'd3 || done_wiid_o !== 4'd0) begin
      bad++;
      $display("FAIL read_hit_rsp: got type=%b wiid=%0d riid=%0d want 1/0/3",
               done_type_o, done_wiid_o, done_riid_o);
    end
    release_done();
    issue(1'b0, 20'h10000, 8'd0, 5'd7, lat);
    total++;
    if (lat !== 105) begin bad++; $display("FAIL read_miss_lat: got %0d want 105", lat); end
    total++;
    if (open_row_o !== 10'h040 || done_riid_o !== 5'd7) begin
      bad++;
      $display("FAIL read_miss_row: got row=%h riid=%0d want 040/7", open_row_o, done_riid_o);
    end
    release_done();
    total++;
    if (busy_o !== 1'b0) begin bad++; $display("FAIL idle_after_release: busy=%b want 0", busy_o); end
  endtask

  task automatic test_close_page();
    int lat;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, 20'h00400, 8'd0, 5'(i + 1), lat);
      total++;
      if (lat !== 55) begin bad++; $display("FAIL close_lat_%0d: got %0d want 55", i, lat); end
      total++;
      if (row_open_o !== 1'b0 || open_row_o !== '0 || done_wiid_o !== 4'(i + 1)) begin
        bad++;
        $display("FAIL close_row_%0d: got open=%b row=%h wiid=%0d want 0/0/%0d",
                 i, row_open_o, open_row_o, done_wiid_o, i + 1);
      end
      release_done();
    end
  endtask

  task automatic test_round_robin();
    int guard;
    bit exp_w;
    do_reset();
    waddr_i.addr = 20'h00400; waddr_i.burst_len = 8'd0; waddr_iid_i = 4'd1;
    raddr_i.addr = 20'h00400; raddr_i.burst_len = 8'd0; raddr_iid_i = 5'd2;
    waddr_valid_i = 1'b1; raddr_valid_i = 1'b1;
    for (int b = 0; b < 4; b++) begin
      exp_w = (b % 2 == 0);
      guard = 0;
      @(negedge clk_i);
      while (!(waddr_ready_o || raddr_ready_o) && guard < 50) begin
        @(negedge clk_i);
        guard++;
      end
      total++;
      if (waddr_ready_o !== exp_w || raddr_ready_o !== !exp_w) begin
        bad++;
        $display("FAIL rr_grant_%0d: got wr=%b rr=%b want wr=%b rr=%b",
                 b, waddr_ready_o, raddr_ready_o, exp_w, !exp_w);
      end
      @(posedge clk_i); #1;
      guard = 0;
      @(negedge clk_i);
      while (!done_valid_o && guard < 300) begin
        @(negedge clk_i);
        guard++;
      end
      total++;
      if (done_valid_o !== 1'b1 || done_type_o !== (exp_w ? WRSP_BANK : RDATA_BANK)) begin
        bad++;
        $display("FAIL rr_done_%0d: got v=%b type=%b want v=1 type=%b",
                 b, done_valid_o, done_type_o, !exp_w);
      end
      total++;
      if (waddr_ready_o !== 1'b0 || raddr_ready_o !== 1'b0) begin
        bad++;
        $display("FAIL rr_hold_%0d: got wr=%b rr=%b want 0/0", b, waddr_ready_o, raddr_ready_o);
      end
      release_done();
    end
    waddr_valid_i = 1'b0; raddr_valid_i = 1'b0;
  endtask

  task automatic test_backpressure();
    int lat;
    int exp_lat;
    // Row 2 after row 0x40 was left open: conflict in open-page mode.
    exp_lat = ClosePage ? 56 : 106;
    issue(1'b1, 20'h00800, 8'd1, 5'd9, lat);
    total++;
    if (lat !== exp_lat) begin bad++; $display("FAIL bp_lat: got %0d want %0d", lat, exp_lat); end
    raddr_i.addr = 20'h00000; raddr_valid_i = 1'b1;
    waddr_i.addr = 20'h00000; waddr_valid_i = 1'b1;
    for (int c = 0; c < 20; c++) begin
      total++;
      if (done_valid_o !== 1'b1 || done_wiid_o !== 4'd9 || done_type_o !== WRSP_BANK) begin
        bad++;
        $display("FAIL bp_stable_%0d: got v=%b wiid=%0d type=%b want 1/9/0",
                 c, done_valid_o, done_wiid_o, done_type_o);
      end
      total++;
      if (waddr_ready_o !== 1'b0 || raddr_ready_o !== 1'b0) begin
        bad++;
        $display("FAIL bp_ready_%0d: got wr=%b rr=%b want 0/0", c, waddr_ready_o, raddr_ready_o);
      end
      @(negedge clk_i);
    end
    waddr_valid_i = 1'b0; raddr_valid_i = 1'b0;
    release_done();
  endtask

  task automatic test_reset_mid_busy();
    int lat;
    do_reset();
    issue(1'b1, 20'h00400, 8'd0, 5'd4, lat);
    release_done();
    waddr_i.addr = 20'h00400; waddr_i.burst_len = 8'd0; waddr_iid_i = 4'd6; waddr_valid_i = 1'b1;
    @(posedge clk_i); #1;
    waddr_valid_i = 1'b0;
    repeat (5) @(negedge clk_i);
    total++;
    if (busy_o !== 1'b1 || row_open_o !== ~ClosePage) begin
      bad++;
      $display("FAIL mid_busy_pre: got busy=%b open=%b want 1/%b", busy_o, row_open_o, ~ClosePage);
    end
    #2 rst_ni = 1'b0;
    #1;
    total++;
    if ({busy_o, row_open_o, done_valid_o} !== 3'b0 || open_row_o !== '0) begin
      bad++;
      $display("FAIL mid_busy_abort: got busy=%b open=%b v=%b row=%h want 0",
               busy_o, row_open_o, done_valid_o, open_row_o);
    end
    @(posedge clk_i); #1 rst_ni = 1'b1;
    @(posedge clk_i); #1;
    issue(1'b1, 20'h00400, 8'd0, 5'd8, lat);
    total++;
    if (lat !== 55 || done_wiid_o !== 4'd8) begin
      bad++;
      $display("FAIL post_reset_lat: got lat=%0d wiid=%0d want 55/8", lat, done_wiid_o);
    end
    release_done();
  endtask

  initial begin
    test_reset();
    if (ClosePage) test_close_page();
    else           test_open_page();
    test_backpressure();
    test_round_robin();
    test_reset_mid_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
